// File: rtl/riscv_div_pkg.sv
// Shared constants and types for the RV32M iterative divider.
// Latency: n/a (package). Backpressure: n/a.
package riscv_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUO = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring division iteration: shift {rem,quo} left, subtract divisor if it fits.
// Latency: combinational. Backpressure: none.
module riscv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         fits;

    // The shifted partial remainder is W+1 bits; when the divisor fits, the
    // difference is below the divisor, so the low W bits of a modular subtract are exact.
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        fits    = (shifted >= {1'b0, div_i});
        diff    = shifted[W-1:0] - div_i;
        rem_o   = fits ? diff : shifted[W-1:0];
        quo_o   = {quo_i[W-2:0], fits};
    end

endmodule

// File: rtl/riscv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider in EX; early-out via RISCV_DIV_EARLY_OUT_EN.
// Latency: 33 stall cycles + result cycle (special/early-out: 1 + 1). Backpressure: div_stall freezes F/D; flush kills.
module riscv_div_unit
    import riscv_div_pkg::*;
#(
    parameter int XLEN  = riscv_div_pkg::XLEN,
    parameter int CNT_W = riscv_div_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            div_stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            rem_sel_q, rem_sel_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            is_signed, b_zero, sgn_ovf, go;

    riscv_div_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        is_signed = ~funct3[0];
        abs_a     = abs_val(op_a, is_signed);
        abs_b     = abs_val(op_b, is_signed);
        b_zero    = (op_b == '0);
        sgn_ovf   = is_signed && (op_a == INT_MIN) && (op_b == '1);
        go        = start && funct3[2] && !flush;
    end

    always_comb begin
        state_d      = state_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvsr_d       = dvsr_q;
        cnt_d        = cnt_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        rem_sel_d    = rem_sel_q;
        div_stall    = 1'b0;
        result_valid = 1'b0;
        result       = '0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    div_stall = 1'b1;
                    rem_sel_d = funct3[1];
                    neg_quo_d = is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]) && !b_zero;
                    neg_rem_d = is_signed && op_a[XLEN-1];
                    dvsr_d    = abs_b;
                    cnt_d     = '0;
                    // Remainder is kept as a magnitude; the sign fix-up in DONE restores op_a.
                    if (b_zero) begin
                        quo_d   = DIV0_QUO;
                        rem_d   = abs_a;
                        state_d = S_DONE;
                    end else if (sgn_ovf) begin
                        quo_d   = INT_MIN;
                        rem_d   = '0;
                        state_d = S_DONE;
`ifdef RISCV_DIV_EARLY_OUT_EN
                    end else if (abs_a < abs_b) begin
                        quo_d   = '0;
                        rem_d   = abs_a;
                        state_d = S_DONE;
`endif
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                div_stall = 1'b1;
                quo_d     = step_quo;
                rem_d     = step_rem;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (rem_sel_q) begin
                    result = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                end else begin
                    result = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The redirect must never be held off by a divide it is about to kill.
        if (flush) begin
            state_d   = S_IDLE;
            div_stall = 1'b0;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: directed table, corner sequences, random ops vs arithmetic model.
module tb_riscv_div_unit;
    import riscv_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = F3_DIVU;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        div_stall, busy, result_valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .div_stall    (div_stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RISCV_DIV_EARLY_OUT_EN
        begin
            logic [31:0] ma, mb;
            ma = (!f3[0] && a[31]) ? -a : a;
            mb = (!f3[0] && b[31]) ? -b : b;
            if (ma < mb) return 1;
        end
`endif
        return 33;
    endfunction

    // Called just after a posedge; holds start until result_valid, counts stall cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle, output logic [31:0] res, output int stalls, output bit got);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1;
        stalls = int'(div_stall);
        got = 1'b0;
        res = 'x;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                got = 1'b1;
                res = result;
            end else begin
                stalls += int'(div_stall);
                if (toggle) begin
                    op_a = $urandom;
                    op_b = $urandom;
                end
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] res;
    int          stalls;
    bit          got;

    initial begin
        tbl[0]  = '{F3_DIVU, 32'd100,        32'd7,          32'd14};
        tbl[1]  = '{F3_REMU, 32'd100,        32'd7,          32'd2};
        tbl[2]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        tbl[3]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        tbl[4]  = '{F3_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        tbl[5]  = '{F3_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        tbl[6]  = '{F3_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        tbl[7]  = '{F3_REM,  32'd5,          32'd0,          32'd5};
        tbl[8]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        tbl[9]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        tbl[10] = '{F3_DIVU, 32'd3,          32'd10,         32'd0};
        tbl[11] = '{F3_REMU, 32'd3,          32'd10,         32'd3};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(div_stall), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 1'b0, res, stalls, got);
            check($sformatf("vec%0d_got", i), 32'(got), 32'd1);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(ref_latency(tbl[i].f3, tbl[i].a, tbl[i].b)));
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle_valid", i), 32'(result_valid), 32'd0);
            check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
        end

        // Flush on the 10th CALC cycle, then a fresh divide two cycles later.
        funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("flush_pre_busy", 32'(busy), 32'd1);
        check("flush_pre_stall", 32'(div_stall), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(div_stall), 32'd0);
        @(posedge clk); #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(result_valid), 32'd0);
        flush = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("flush_valid2", 32'(result_valid), 32'd0);
        run_op(F3_DIVU, 32'd1000, 32'd3, 1'b0, res, stalls, got);
        check("post_flush_got", 32'(got), 32'd1);
        check("post_flush_result", res, 32'd333);
        check("post_flush_stalls", 32'(stalls), 32'd33);
        @(posedge clk); #1;

        // Synchronous reset mid-CALC.
        funct3 = F3_DIV; op_a = 32'd12345678; op_b = 32'hFFFF_FF9D; start = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(div_stall), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_after_valid", 32'(result_valid), 32'd0);
        end

        // Operand wiggling during CALC must not disturb the captured divide.
        run_op(F3_DIVU, 32'd1000000, 32'd37, 1'b1, res, stalls, got);
        check("toggle_got", 32'(got), 32'd1);
        check("toggle_result", res, 32'd27027);
        check("toggle_stalls", 32'(stalls), 32'd33);
        @(posedge clk); #1;

        for (int i = 0; i < 50; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 20));
                1: b = -32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = a + 32'($urandom_range(1, 1000));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(f3, a, b, 1'b0, res, stalls, got);
            check($sformatf("rnd%0d_got", i), 32'(got), 32'd1);
            check($sformatf("rnd%0d_f3=%0d_a=%08h_b=%08h", i, f3, a, b), res, ref_result(f3, a, b));
            check($sformatf("rnd%0d_stalls", i), 32'(stalls), 32'(ref_latency(f3, a, b)));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
